phase_timer: RTL and testbench

Phase-duration timer for the traffic-light controller: the datapath partner of the light-sequencing FSM. It consumes the FSM's `load_enable` and `time_sel`, counts the selected phase length in seconds-ticks derived from `clk`, and returns a single-cycle `timer_zero` pulse when the phase expires. Green and yellow durations are runtime-programmable through a small configuration port.

---
 rtl/tlc_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 35 +++
 rtl/phase_timer.sv | 96 +++++++++
 tb/tb_phase_timer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// ---------------------------------------------------------------------------
// tlc_pkg : shared definitions for the traffic-light controller.
//   TSEL_*      : time_sel encodings (green / yellow phase duration select)
//   light_t     : light command encodings driven by the sequencing FSM
//   GREEN_DEF   : green phase length in ticks after reset
//   YELLOW_DEF  : yellow phase length in ticks after reset
// ---------------------------------------------------------------------------
package tlc_pkg;

  localparam logic TSEL_GREEN  = 1'b0;
  localparam logic TSEL_YELLOW = 1'b1;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  localparam int GREEN_DEF  = 30;
  localparam int YELLOW_DEF = 5;

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler : divides clk down to a one-cycle tick strobe.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, prescaler -> 0
//   clr   : restart the division period (prescaler -> 0)
//   tick  : combinational strobe, high while the prescaler is at TICK_DIV-1
// With TICK_DIV = 1 the prescaler never leaves 0, so tick is constantly 1.
// ---------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre;

  assign tick = (pre == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer : phase-duration timer, datapath partner of the light FSM.
//   clk         : clock, rising edge
//   reset       : synchronous active-high reset
//   load_enable : reload count with the duration chosen by time_sel
//   time_sel    : 0 = green duration, 1 = yellow duration
//   cfg_we      : write enable for the duration registers
//   cfg_sel     : 0 = write green duration, 1 = write yellow duration
//   cfg_data    : duration to write (0 is stored as 1)
//   timer_zero  : registered one-cycle pulse when a tick takes count 1 -> 0
//   time_left   : current count, for display
//   tick        : prescaler strobe, for debug/display
// ---------------------------------------------------------------------------
module phase_timer
  import tlc_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int CNT_W      = 8,
  parameter int GREEN_DEF  = tlc_pkg::GREEN_DEF,
  parameter int YELLOW_DEF = tlc_pkg::YELLOW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_enable,
  input  logic             time_sel,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             timer_zero,
  output logic [CNT_W-1:0] time_left,
  output logic             tick
);

  localparam logic [CNT_W-1:0] GREEN_INIT  = CNT_W'(GREEN_DEF);
  localparam logic [CNT_W-1:0] YELLOW_INIT = CNT_W'(YELLOW_DEF);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  // A zero-length phase would never expire, so the shortest duration is 1.
  function automatic logic [CNT_W-1:0] sat_dur(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  logic [CNT_W-1:0] green_dur;
  logic [CNT_W-1:0] yellow_dur;
  logic [CNT_W-1:0] count;

  // Every phase starts on a full tick period: a load restarts the prescaler.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (load_enable),
    .tick  (tick)
  );

  // Duration registers. A load in the same cycle as a write still reads
  // the old value, so writes only affect later phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      green_dur  <= GREEN_INIT;
      yellow_dur <= YELLOW_INIT;
    end else if (cfg_we) begin
      if (cfg_sel == TSEL_YELLOW) begin
        yellow_dur <= sat_dur(cfg_data);
      end else begin
        green_dur <= sat_dur(cfg_data);
      end
    end
  end

  // Down counter. The FSM leaves reset in NS-green without a load, so
  // reset itself loads the green default.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= GREEN_INIT;
    end else if (load_enable) begin
      count <= (time_sel == TSEL_YELLOW) ? yellow_dur : green_dur;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Expiry pulse: only the 1 -> 0 transition fires, so a count parked at 0
  // stays silent, and a reload abandons the old phase without a pulse.
  always_ff @(posedge clk) begin
    if (reset || load_enable) begin
      timer_zero <= 1'b0;
    end else begin
      timer_zero <= tick && (count == ONE);
    end
  end

  assign time_left = count;

endmodule

// File: tb/tb_phase_timer.sv
module tb_phase_timer;
  import tlc_pkg::*;

  localparam int T  = 4;
  localparam int GD = 3;
  localparam int YD = 2;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_enable = 1'b0;
  logic         time_sel = 1'b0;
  logic         cfg_we = 1'b0;
  logic         cfg_sel = 1'b0;
  logic [W-1:0] cfg_data = '0;
  logic         timer_zero;
  logic [W-1:0] time_left;
  logic         tick;

  always #5 clk = ~clk;

  phase_timer #(
    .TICK_DIV   (T),
    .CNT_W      (W),
    .GREEN_DEF  (GD),
    .YELLOW_DEF (YD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_enable (load_enable),
    .time_sel    (time_sel),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .timer_zero  (timer_zero),
    .time_left   (time_left),
    .tick        (tick)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edges since the last load/reset, the duration that
  // load selected, and the programmed durations.
  int m_n   = 0;
  int m_d   = GD;
  int m_grn = GD;
  int m_yel = YD;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, update model at posedge, check after.
  task automatic step(input logic rst, input logic ld, input logic sel,
                      input logic we, input logic csel, input logic [W-1:0] data);
    int exp_cnt;
    @(negedge clk);
    reset       = rst;
    load_enable = ld;
    time_sel    = sel;
    cfg_we      = we;
    cfg_sel     = csel;
    cfg_data    = data;
    @(posedge clk);
    if (rst) begin
      m_n = 0; m_d = GD; m_grn = GD; m_yel = YD; cyc = 0;
    end else begin
      cyc++;
      if (ld) begin
        m_d = sel ? m_yel : m_grn;
        m_n = 0;
      end else if (m_n < 100000) begin
        m_n++;
      end
      if (we) begin
        if (csel) m_yel = (data == 0) ? 1 : int'(data);
        else      m_grn = (data == 0) ? 1 : int'(data);
      end
    end
    #1;
    exp_cnt = (m_n / T >= m_d) ? 0 : m_d - m_n / T;
    check_val("time_left", time_left, exp_cnt);
    check_bit("timer_zero", timer_zero, m_n == m_d * T);
    check_bit("tick", tick, (m_n % T) == T - 1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int exp_len [6];
    int ph, pend, last, nph;
    exp_len = '{13, 10, 14, 10, 14, 10};

    // Reset, then free-run green expiry from reset release
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_val("reset_time_left", time_left, 3);
    check_bit("reset_timer_zero", timer_zero, 1'b0);
    idle(11);
    check_bit("green_pre_expiry", timer_zero, 1'b0);
    idle(1);
    check_bit("green_expiry_at_12", timer_zero, 1'b1);
    check_val("green_expiry_count", time_left, 0);
    idle(1);
    check_bit("green_single_pulse", timer_zero, 1'b0);
    idle(8);

    // Yellow load and expiry 8 cycles later
    step(1'b0, 1'b1, TSEL_YELLOW, 1'b0, 1'b0, '0);
    check_val("yellow_load", time_left, 2);
    idle(7);
    check_bit("yellow_pre_expiry", timer_zero, 1'b0);
    idle(1);
    check_bit("yellow_expiry_at_8", timer_zero, 1'b1);

    // Reload at count 1, one cycle before a tick: old phase abandoned
    step(1'b0, 1'b1, TSEL_YELLOW, 1'b0, 1'b0, '0);
    idle(6);
    check_val("before_reload", time_left, 1);
    step(1'b0, 1'b1, TSEL_GREEN, 1'b0, 1'b0, '0);
    check_val("reload_green", time_left, 3);
    check_bit("reload_no_tick", tick, 1'b0);
    idle(12);

    // Zero write saturates to 1; write coincident with load uses old value
    step(1'b0, 1'b0, 1'b0, 1'b1, TSEL_YELLOW, 8'd0);
    step(1'b0, 1'b1, TSEL_YELLOW, 1'b0, 1'b0, '0);
    check_val("yellow_zero_write", time_left, 1);
    step(1'b0, 1'b1, TSEL_GREEN, 1'b1, TSEL_GREEN, 8'd7);
    check_val("green_old_value", time_left, 3);
    step(1'b0, 1'b1, TSEL_GREEN, 1'b0, 1'b0, '0);
    check_val("green_new_value", time_left, 7);

    // Mid-phase reset restores defaults
    step(1'b0, 1'b0, 1'b0, 1'b1, TSEL_YELLOW, 8'd9);
    step(1'b0, 1'b1, TSEL_YELLOW, 1'b0, 1'b0, '0);
    check_val("yellow_custom", time_left, 9);
    idle(28);
    check_val("mid_phase", time_left, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_val("midreset_time_left", time_left, 3);
    check_bit("midreset_timer_zero", timer_zero, 1'b0);
    step(1'b0, 1'b1, TSEL_YELLOW, 1'b0, 1'b0, '0);
    check_val("yellow_reverted", time_left, 2);

    // Random stimulus against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(199) == 0, $urandom_range(24) == 0, 1'($urandom),
           $urandom_range(7) == 0, 1'($urandom), W'($urandom_range(3)));
    end

    // Closed loop with a behavioural light FSM
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    ph = 0; pend = 0; last = 0; nph = 0;
    for (int k = 0; k < 300 && nph < 6; k++) begin
      logic ld_c;
      logic sel_c;
      ld_c  = (pend == 1);
      sel_c = (ph % 2 == 1);
      if (pend > 0) pend--;
      step(1'b0, ld_c, sel_c, 1'b0, 1'b0, '0);
      if (timer_zero === 1'b1) begin
        check_val("phase_len", cyc + 1 - last, exp_len[nph]);
        last = cyc + 1;
        nph++;
        ph   = (ph + 1) % 4;
        pend = 2;
      end
    end
    check_val("phase_count", nph, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
